// File: rtl/maxpool_1d_stream_if.sv
// Valid/ready stream bundle shared by the pooling stage and its neighbours.
// The producer uses the master view and the consumer uses the slave view.
interface maxpool_1d_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/maxpool_1d_stream.sv
// Non-overlapping 1-D max pooling over signed samples.
// Windows restart at every upstream vector boundary, and each window result is held in a single output register.
module maxpool_1d_stream #(
  parameter int WIDTH   = 8,
  parameter int WIN     = 2,
  parameter int VEC_LEN = 5
) (
  input logic                 clk,
  input logic                 reset,
  maxpool_1d_stream_if.slave  s_y,
  maxpool_1d_stream_if.master m_z
);

  localparam int WCW = $clog2(WIN) + 1;
  localparam int PW  = $clog2(VEC_LEN) + 1;
  localparam logic [WCW-1:0] WinLast = WCW'(WIN - 1);
  localparam logic [PW-1:0]  PosLast = PW'(VEC_LEN - 1);

  logic [WCW-1:0]          winCnt_q, winCnt_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic signed [WIDTH-1:0] runMax_q, runMax_d;
  logic [WIDTH-1:0]        outData_q, outData_d;
  logic                    outValid_q, outValid_d;

  logic signed [WIDTH-1:0] sample;
  logic signed [WIDTH-1:0] merged;
  logic                    sReady;
  logic                    accept;
  logic                    closeWin;

  // A sample may enter whenever the output slot is empty or being drained this cycle.
  assign sReady    = !reset && (!outValid_q || m_z.ready);
  assign s_y.ready = sReady;
  assign accept    = s_y.valid && sReady;
  assign sample    = $signed(s_y.data);
  assign closeWin  = (winCnt_q == WinLast) || (pos_q == PosLast);
  assign merged    = ((winCnt_q == '0) || (sample > runMax_q)) ? sample : runMax_q;

  assign m_z.data  = outData_q;
  assign m_z.valid = outValid_q;

  always_comb begin
    winCnt_d   = winCnt_q;
    pos_d      = pos_q;
    runMax_d   = runMax_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    if (outValid_q && m_z.ready) begin
      outValid_d = 1'b0;
    end
    if (accept) begin
      runMax_d = merged;
      if (closeWin) begin
        outData_d  = merged;
        outValid_d = 1'b1;
        winCnt_d   = '0;
      end else begin
        winCnt_d = winCnt_q + WCW'(1);
      end
      pos_d = (pos_q == PosLast) ? '0 : pos_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      winCnt_q   <= '0;
      pos_q      <= '0;
      runMax_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      winCnt_q   <= winCnt_d;
      pos_q      <= pos_d;
      runMax_q   <= runMax_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: doc/maxpool_1d_stream.md
Name: maxpool_1d_stream

Overview:
- Downstream stage of the 8-point, 4-tap streaming convolution (`conv_8_4_8_1`).
- Consumes its signed 8-bit y stream: 5 outputs per input vector.
- Applies non-overlapping 1-D max pooling, window WIN, stride WIN, restarting at each vector boundary.
- A trailing partial window at the vector end emits the max of the samples it holds.
- Valid/ready handshake on both sides; one registered output slot; full throughput.

Parameters:
WIDTH, 8, sample width; signed two's complement.
WIN, 2, pooling window length and stride; must be >= 1.
VEC_LEN, 5, samples per upstream vector; must be >= 1. Outputs per vector = ceil(VEC_LEN/WIN).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
s_data_in_y  input  WIDTH  signed upstream sample.
s_valid_y  input  1  upstream sample valid.
s_ready_y  output  1  block can accept a sample this cycle.
m_data_out_z  output  WIDTH  signed pooled result.
m_valid_z  output  1  m_data_out_z holds an unconsumed result.
m_ready_z  input  1  downstream accepts the result this cycle.

Behaviour:
- Reset state (reset=1 at a clock edge, regardless of other inputs):
  - m_valid_z=0, m_data_out_z=0.
  - Window count, vector position and running max all cleared to 0.
  - Any partial window or pending output is discarded.
- s_ready_y = !reset && (!m_valid_z || m_ready_z). This is combinational; s_ready_y must not depend on s_valid_y.
- An input is accepted when s_valid_y && s_ready_y at a rising edge.
- Per accepted sample:
  - If win_cnt==0: run_max <= sample.
  - Otherwise: run_max <= signed max(run_max, sample). On ties, either value may be kept; the result is identical.
- Window close: the accepted sample closes the window if win_cnt==WIN-1 OR pos==VEC_LEN-1.
  - On close: m_data_out_z <= (win_cnt==0 ? sample : max(run_max, sample)); m_valid_z <= 1; win_cnt <= 0.
  - Not closed: win_cnt <= win_cnt+1.
- Vector position:
  - pos==VEC_LEN-1 on accept: pos <= 0, and win_cnt <= 0 (forced window close).
  - Otherwise: pos <= pos+1.
- Latency: result visible on m_data_out_z / m_valid_z one cycle after the closing sample's accept edge.
- Output handshake:
  - A result is consumed when m_valid_z && m_ready_z at an edge.
  - If consumed and no new close occurs on that edge, m_valid_z <= 0 and m_data_out_z holds its value.
  - If consumed and a closing sample is accepted on the same edge, the new result loads and m_valid_z stays 1.
  - While m_valid_z && !m_ready_z: m_data_out_z and m_valid_z are held stable; s_ready_y=0, so no samples are accepted.
- Throughput: with s_valid_y and m_ready_z held high, one sample is accepted every cycle; no bubbles.
- Arithmetic: comparisons are signed WIDTH-bit. There is no saturation, since max cannot overflow.
- Counter widths: win_cnt is $clog2(WIN)+1 bits; pos is $clog2(VEC_LEN)+1 bits; no wrap other than the rules above.
- WIN==1: every sample closes a window; the output equals the input delayed by one register.
- WIN>=VEC_LEN: one output per vector, equal to the max of all VEC_LEN samples.
- s_data_in_y is ignored when s_valid_y=0; X on it must not propagate to any state.

Test Plan:
- Basic vector, WIN=2, VEC_LEN=5, valid/ready always high: y = 10,3,7,20,5 -> z = 10,20,5. Each z appears 1 cycle after y[1], y[3] and y[4] are accepted.
- Signed compare: y = -5,-2,-128,127,-1 -> z = -2,127,-1. Next vector y = 0,-1,-1,0,-7 -> z = 0,0,-7; confirms per-vector restart.
- Backpressure: m_ready_z=0 for 6 cycles after the first result:
  - m_valid_z stays 1 and m_data_out_z stays 10.
  - s_ready_y stays 0 and no samples are lost.
  - After release, the stream continues and yields 20,5.
- Simultaneous events: result pending; m_ready_z=1 on the same edge a closing sample is accepted. m_valid_z stays 1 and the next value loads. Over 100 random vectors with random s_valid_y / m_ready_z, the sequence matches the reference model exactly.
- Reset mid-window: after y = 50 is accepted (win_cnt=1), assert reset for 1 cycle.
  - m_valid_z=0 and m_data_out_z=0.
  - Then y = 1,2,3,4,5 -> z = 2,4,5; the stale 50 never appears.
- Parameter sweep: (WIN=1, VEC_LEN=5) gives z==y; (WIN=5, VEC_LEN=5) with y=3,9,-4,8,1 gives z=9; (WIN=3, VEC_LEN=5) with y=1,6,2,7,0 gives z=6,7.
